// File: rtl/rv_structs.sv
// Shared pipeline-control types: hazard FSM state encoding and register index width.
package rv_structs;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_MC_WAIT = 2'd1,
    HZ_FLUSH   = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/rv_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and rv_hazard_ctrl (slave).
interface rv_hazard_ctrl_if;
  import rv_structs::*;

  logic [REG_W-1:0] i_dec_rs1, i_dec_rs2, i_alu1_rd;
  logic i_dec_rs1_used, i_dec_rs2_used, i_alu1_load, i_alu1_reg_write;
  logic i_mc_req, i_mc_done, i_pc_change, i_trap, i_mem_busy;
  logic o_stall_fetch, o_stall_decode, o_stall_alu1, o_flush_decode, o_flush_alu1;
  logic o_mc_start, o_mc_kill, o_mc_timeout, o_busy;
  logic [1:0] o_state;

  modport master (
    output i_dec_rs1, i_dec_rs2, i_dec_rs1_used, i_dec_rs2_used, i_alu1_rd, i_alu1_load,
           i_alu1_reg_write, i_mc_req, i_mc_done, i_pc_change, i_trap, i_mem_busy,
    input  o_stall_fetch, o_stall_decode, o_stall_alu1, o_flush_decode, o_flush_alu1,
           o_mc_start, o_mc_kill, o_mc_timeout, o_busy, o_state
  );

  modport slave (
    input  i_dec_rs1, i_dec_rs2, i_dec_rs1_used, i_dec_rs2_used, i_alu1_rd, i_alu1_load,
           i_alu1_reg_write, i_mc_req, i_mc_done, i_pc_change, i_trap, i_mem_busy,
    output o_stall_fetch, o_stall_decode, o_stall_alu1, o_flush_decode, o_flush_alu1,
           o_mc_start, o_mc_kill, o_mc_timeout, o_busy, o_state
  );
endinterface

// File: rtl/rv_hazard_lu.sv
// Load-use detector: load in alu1 writes a non-x0 register that decode actually reads.
module rv_hazard_lu
  import rv_structs::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd,
  input  logic             load,
  input  logic             reg_write,
  output logic             hazard
);
  logic hit1, hit2;

  assign hit1   = rs1_used && (rs1 == rd);
  assign hit2   = rs2_used && (rs2 == rd);
  assign hazard = load && reg_write && (rd != '0) && (hit1 || hit2);
endmodule

// File: rtl/rv_hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, memory wait, multi-cycle op wait, load-use.
// Optional RV_HAZARD_MC_TIMEOUT_EN aborts a multi-cycle op after MC_MAX_CYCLES cycles.
module rv_hazard_ctrl
  import rv_structs::*;
#(
  parameter int FLUSH_CYCLES  = 2,
  parameter int MC_MAX_CYCLES = 34
) (
  input logic             i_clk,
  input logic             i_reset_n,
  rv_hazard_ctrl_if.slave hz
);
  localparam int         MCW     = $clog2(MC_MAX_CYCLES);
  localparam logic [2:0] FL_LAST = 3'(FLUSH_CYCLES - 1);

  hazard_state_t  state, state_nxt;
  logic [MCW-1:0] mc_cnt, mc_cnt_nxt;
  logic [2:0]     fl_cnt, fl_cnt_nxt;
  logic           lu_hazard, redirect;
  logic stall_f, stall_d, stall_a, flush_d, flush_a, mc_start, mc_kill, mc_tmo;

  rv_hazard_lu u_lu (
    .rs1       (hz.i_dec_rs1),
    .rs2       (hz.i_dec_rs2),
    .rs1_used  (hz.i_dec_rs1_used),
    .rs2_used  (hz.i_dec_rs2_used),
    .rd        (hz.i_alu1_rd),
    .load      (hz.i_alu1_load),
    .reg_write (hz.i_alu1_reg_write),
    .hazard    (lu_hazard)
  );

  assign redirect = hz.i_trap || hz.i_pc_change;

  always_comb begin
    {stall_f, stall_d, stall_a, flush_d, flush_a, mc_start, mc_kill, mc_tmo} = '0;
    state_nxt  = state;
    mc_cnt_nxt = mc_cnt;
    fl_cnt_nxt = fl_cnt;
    if (redirect) begin
      // Redirect overrides everything and cancels an in-flight multi-cycle op.
      {flush_d, flush_a} = 2'b11;
      mc_kill    = (state == HZ_MC_WAIT);
      state_nxt  = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
      fl_cnt_nxt = 3'd1;
    end else begin
      case (state)
        HZ_RUN: begin
          if (hz.i_mem_busy) begin
            {stall_f, stall_d, stall_a} = 3'b111;
          end else if (hz.i_mc_req) begin
            {stall_f, stall_d, stall_a} = 3'b111;
            mc_start   = 1'b1;
            state_nxt  = HZ_MC_WAIT;
            mc_cnt_nxt = '0;
          end else if (lu_hazard) begin
            {stall_f, stall_d, flush_a} = 3'b111;
          end
        end
        HZ_MC_WAIT: begin
          if (hz.i_mem_busy) begin
            {stall_f, stall_d, stall_a} = 3'b111;
          end else if (hz.i_mc_done) begin
            state_nxt = HZ_RUN;
`ifdef RV_HAZARD_MC_TIMEOUT_EN
          end else if (mc_cnt == MCW'(MC_MAX_CYCLES - 1)) begin
            mc_tmo    = 1'b1;
            mc_kill   = 1'b1;
            state_nxt = HZ_RUN;
`endif
          end else begin
            {stall_f, stall_d, stall_a} = 3'b111;
            mc_cnt_nxt = mc_cnt + MCW'(1);
          end
        end
        HZ_FLUSH: begin
          {flush_d, flush_a} = 2'b11;
          fl_cnt_nxt = fl_cnt + 3'd1;
          if (fl_cnt == FL_LAST) state_nxt = HZ_RUN;
        end
        default: state_nxt = HZ_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= HZ_RUN;
      mc_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
      fl_cnt <= fl_cnt_nxt;
    end
  end

  // Outputs are gated by reset so they drop the instant reset asserts.
  assign hz.o_stall_fetch  = i_reset_n & stall_f;
  assign hz.o_stall_decode = i_reset_n & stall_d;
  assign hz.o_stall_alu1   = i_reset_n & stall_a;
  assign hz.o_flush_decode = i_reset_n & flush_d;
  assign hz.o_flush_alu1   = i_reset_n & flush_a;
  assign hz.o_mc_start     = i_reset_n & mc_start;
  assign hz.o_mc_kill      = i_reset_n & mc_kill;
`ifdef RV_HAZARD_MC_TIMEOUT_EN
  assign hz.o_mc_timeout   = i_reset_n & mc_tmo;
`else
  assign hz.o_mc_timeout   = 1'b0;
`endif
  assign hz.o_busy         = i_reset_n & (state != HZ_RUN);
  assign hz.o_state        = i_reset_n ? state : 2'b00;
endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed bench for rv_hazard_ctrl: two instances (FLUSH_CYCLES=3/MC_MAX=8 and FLUSH_CYCLES=1).
module tb_rv_hazard_ctrl;
  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       load, rw, mc_req, mc_done, pc, trap, busy;
  } in_t;

  // Output vector: {sf,sd,sa, fd,fa, start,kill,tmo, busy, state[1:0]}
  localparam logic [10:0] O_IDLE   = 11'b000_00_000_0_00;
  localparam logic [10:0] O_LU     = 11'b110_01_000_0_00;
  localparam logic [10:0] O_STALL  = 11'b111_00_000_0_00;
  localparam logic [10:0] O_START  = 11'b111_00_100_0_00;
  localparam logic [10:0] O_MCW    = 11'b111_00_000_1_01;
  localparam logic [10:0] O_DONE   = 11'b000_00_000_1_01;
  localparam logic [10:0] O_RD_RUN = 11'b000_11_000_0_00;
  localparam logic [10:0] O_RD_MCW = 11'b000_11_010_1_01;
  localparam logic [10:0] O_RD_FL  = 11'b000_11_000_1_10;
  localparam logic [10:0] O_FLUSH  = 11'b000_11_000_1_10;
`ifdef RV_HAZARD_MC_TIMEOUT_EN
  localparam logic [10:0] O_TMO    = 11'b000_00_011_1_01;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  in = '0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rv_hazard_ctrl_if a ();
  rv_hazard_ctrl_if b ();

  assign {a.i_dec_rs1, a.i_dec_rs2, a.i_dec_rs1_used, a.i_dec_rs2_used, a.i_alu1_rd, a.i_alu1_load,
          a.i_alu1_reg_write, a.i_mc_req, a.i_mc_done, a.i_pc_change, a.i_trap, a.i_mem_busy} = in;
  assign {b.i_dec_rs1, b.i_dec_rs2, b.i_dec_rs1_used, b.i_dec_rs2_used, b.i_alu1_rd, b.i_alu1_load,
          b.i_alu1_reg_write, b.i_mc_req, b.i_mc_done, b.i_pc_change, b.i_trap, b.i_mem_busy} = in;

  rv_hazard_ctrl #(.FLUSH_CYCLES(3), .MC_MAX_CYCLES(8)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .hz(a.slave));
  rv_hazard_ctrl #(.FLUSH_CYCLES(1), .MC_MAX_CYCLES(34)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .hz(b.slave));

  wire [10:0] oa = {a.o_stall_fetch, a.o_stall_decode, a.o_stall_alu1, a.o_flush_decode,
                    a.o_flush_alu1, a.o_mc_start, a.o_mc_kill, a.o_mc_timeout, a.o_busy, a.o_state};
  wire [10:0] ob = {b.o_stall_fetch, b.o_stall_decode, b.o_stall_alu1, b.o_flush_decode,
                    b.o_flush_alu1, b.o_mc_start, b.o_mc_kill, b.o_mc_timeout, b.o_busy, b.o_state};

  task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in    = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset forces outputs low even with redirect/mc inputs active.
    in.trap = 1'b1; in.mc_req = 1'b1; in.busy = 1'b1;
    settle(); chk("rst_out_a", oa, O_IDLE); chk("rst_out_b", ob, O_IDLE);
    tick(); rst_n = 1'b1; in = '0;
    settle(); chk("idle", oa, O_IDLE);
    tick();

    // Load-use
    in.rd = 5'd5; in.load = 1; in.rw = 1; in.rs1 = 5'd5; in.u1 = 1;
    settle(); chk("lu_rs1", oa, O_LU);
    tick(); in = '0;
    settle(); chk("lu_one_cycle", oa, O_IDLE);
    tick(); in.rd = 5'd0; in.load = 1; in.rw = 1; in.rs1 = 5'd0; in.u1 = 1;
    settle(); chk("lu_rd0", oa, O_IDLE);
    tick(); in = '0; in.rd = 5'd7; in.load = 1; in.rw = 1; in.rs2 = 5'd7;
    settle(); chk("lu_rs2_unused", oa, O_IDLE);
    tick(); in.u2 = 1;
    settle(); chk("lu_rs2", oa, O_LU);
    tick(); in.rw = 0;
    settle(); chk("lu_no_wr", oa, O_IDLE);
    tick(); in.rw = 1; in.busy = 1;
    settle(); chk("membusy_over_lu", oa, O_STALL);
    tick(); in.busy = 0; in.mc_req = 1;
    settle(); chk("mc_over_lu", oa, O_START);
    tick(); do_reset();

    // Multi-cycle op finishing after 10 cycles (default-limit instance)
    in.mc_req = 1;
    settle(); chk("mc_start", ob, O_START);
    for (int i = 0; i < 9; i++) begin
      tick(); settle(); chk($sformatf("mc_wait%0d", i), ob, O_MCW);
    end
    tick(); in.mc_done = 1;
    settle(); chk("mc_done", ob, O_DONE);
    tick(); in = '0;
    settle(); chk("mc_back_run", ob, O_IDLE);
    tick(); do_reset();

    // Trap on cycle 4 of MC_WAIT; mem_busy beats mc_done and holds the counter
    in.mc_req = 1;
    settle(); chk("tr_start", oa, O_START);
    tick(); settle(); chk("tr_w1", oa, O_MCW);
    tick(); in.busy = 1; in.mc_done = 1;
    settle(); chk("tr_busy_over_done", oa, O_MCW);
    tick(); in.busy = 0; in.mc_done = 0;
    settle(); chk("tr_w3", oa, O_MCW);
    tick(); in.trap = 1;
    settle(); chk("tr_kill_a", oa, O_RD_MCW); chk("tr_kill_b", ob, O_RD_MCW);
    tick(); in = '0;
    settle(); chk("tr_flush1", oa, O_FLUSH); chk("tr_f1_run", ob, O_IDLE);
    tick(); settle(); chk("tr_flush2", oa, O_FLUSH);
    tick(); settle(); chk("tr_flush_end", oa, O_IDLE);
    tick();

    // pc_change flush length, restart inside FLUSH, trap beats mc_req
    in.pc = 1;
    settle(); chk("pc_a0", oa, O_RD_RUN); chk("pc_b0", ob, O_RD_RUN);
    tick(); in.pc = 0;
    settle(); chk("pc_a1", oa, O_FLUSH); chk("pc_b1", ob, O_IDLE);
    tick(); settle(); chk("pc_a2", oa, O_FLUSH);
    tick(); settle(); chk("pc_a3", oa, O_IDLE);
    tick(); in.pc = 1;
    settle(); chk("rs_0", oa, O_RD_RUN);
    tick(); in.pc = 0;
    settle(); chk("rs_1", oa, O_FLUSH);
    tick(); in.pc = 1;
    settle(); chk("rs_redir", oa, O_RD_FL);
    tick(); in.pc = 0;
    settle(); chk("rs_2", oa, O_FLUSH);
    tick(); settle(); chk("rs_3", oa, O_FLUSH);
    tick(); settle(); chk("rs_end", oa, O_IDLE);
    tick(); in.trap = 1; in.mc_req = 1;
    settle(); chk("trap_over_mc", oa, O_RD_RUN);
    tick(); do_reset();

    // Multi-cycle limit on the MC_MAX_CYCLES=8 instance
    in.mc_req = 1;
    settle(); chk("to_start", oa, O_START);
    for (int i = 0; i < 7; i++) begin
      tick(); settle(); chk($sformatf("to_w%0d", i), oa, O_MCW);
    end
    tick();
`ifdef RV_HAZARD_MC_TIMEOUT_EN
    settle(); chk("to_pulse", oa, O_TMO);
    tick(); in.mc_req = 0;
    settle(); chk("to_run", oa, O_IDLE);
    tick(); do_reset();
    in.mc_req = 1;
    settle(); chk("tod_start", oa, O_START);
    for (int i = 0; i < 7; i++) begin
      tick(); settle(); chk($sformatf("tod_w%0d", i), oa, O_MCW);
    end
    tick(); in.mc_done = 1;
    settle(); chk("tod_done_wins", oa, O_DONE);
`else
    settle(); chk("no_to_w7", oa, O_MCW);
    tick(); tick(); tick();
    settle(); chk("no_to_w10", oa, O_MCW);
    tick(); in.mc_done = 1;
    settle(); chk("no_to_done", oa, O_DONE);
`endif
    tick(); do_reset();

    // Async reset in the middle of MC_WAIT
    in.mc_req = 1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1; chk("rst_mid_a", oa, O_IDLE); chk("rst_mid_b", ob, O_IDLE);
    in = '0;
    tick(); rst_n = 1'b1;
    settle(); chk("rst_post_run", oa, O_IDLE);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
